// File: rtl/sha256_work_regs.sv
// SHA-256 working-variable bank (a..h), saved hash, round counter and final hash add.
// Optional macro SHA_STEP_STALL_EN adds a step_en port that gates round advance.
module sha256_work_regs #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64,
  parameter int CNT_W  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8*WORD_W-1:0]   h_in,
  input  logic [WORD_W-1:0]     t1,
  input  logic [WORD_W-1:0]     t2,
`ifdef SHA_STEP_STALL_EN
  input  logic                  step_en,
`endif
  output logic                  busy,
  output logic [CNT_W-1:0]      round_idx,
  output logic [8*WORD_W-1:0]   vars_out,
  output logic [8*WORD_W-1:0]   hash_out,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;

  state_t                     state_q, state_d;
  // Word 7 is a / H0 (MSB slice), word 0 is h / H7.
  logic [7:0][WORD_W-1:0]     vars_q, vars_d;
  logic [7:0][WORD_W-1:0]     hsave_q, hsave_d;
  logic [7:0][WORD_W-1:0]     hash_q, hash_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       done_q, done_d;
  logic                       adv;

`ifdef SHA_STEP_STALL_EN
  assign adv = step_en;
`else
  assign adv = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    vars_d  = vars_q;
    hsave_d = hsave_q;
    hash_d  = hash_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          vars_d  = h_in;
          hsave_d = h_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (adv) begin
          for (int i = 0; i < 7; i++) vars_d[i] = vars_q[i+1];
          vars_d[7] = t1 + t2;
          vars_d[3] = vars_q[4] + t1;
          if (cnt_q == CNT_W'(ROUNDS-1)) begin
            cnt_d   = '0;
            state_d = FINAL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FINAL: begin
        for (int i = 0; i < 8; i++) hash_d[i] = hsave_q[i] + vars_q[i];
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The hash datapath is clocked on the falling edge; this bank follows it.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      vars_q  <= '0;
      hsave_q <= '0;
      hash_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vars_q  <= vars_d;
      hsave_q <= hsave_d;
      hash_q  <= hash_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign round_idx = cnt_q;
  assign vars_out  = vars_q;
  assign hash_out  = hash_q;
  assign done      = done_q;

endmodule

// File: doc/sha256_work_regs.md
Name: sha256_work_regs

Overview:
Parametrised working-variable register bank for the SHA-256 compression core. It replaces the eight single-variable registers with one block holding a..h.
- Loads the intermediate hash H0..H7, sequences ROUNDS round updates from externally computed T1/T2, then adds the working variables back into the saved H to form the new hash.
- Publishes the round index that the K/W schedule logic uses.

Parameters:
WORD_W, 32, width of each working variable and hash word
ROUNDS, 64, number of compression rounds per block
CNT_W, 7, width of round counter; must satisfy 2^CNT_W > ROUNDS

Ports:
clk  input  1  clock; all state updates on the falling edge, matching the hash datapath
rst  input  1  synchronous, active-high reset, sampled on the falling edge of clk
start  input  1  begin a block; sampled only in IDLE
h_in  input  8*WORD_W  intermediate hash; H0 in the MSB slice, H7 in the LSB slice
t1  input  WORD_W  round T1 from external Σ1/Ch/K/W logic
t2  input  WORD_W  round T2 from external Σ0/Maj logic
step_en  input  1  round advance enable (present only with SHA_STEP_STALL_EN)
busy  output  1  high in LOAD-to-FINAL span (RUN and FINAL states)
round_idx  output  CNT_W  current round number, 0..ROUNDS-1
vars_out  output  8*WORD_W  a..h; a in the MSB slice
hash_out  output  8*WORD_W  H_i + var_i; H0' in the MSB slice
done  output  1  one-cycle pulse when hash_out updates

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, a..h=0, saved H=0, round_idx=0, hash_out=0, busy=0, done=0. Reset overrides everything, including mid-block; an in-flight block is discarded with no done pulse.
- FSM states: IDLE, RUN, FINAL.
- IDLE, start=1: load a..h <= H0..H7, save H0..H7 internally, round_idx <= 0, go RUN.
- IDLE, start=0: hold all state. hash_out holds the last result.
- RUN, when advancing:
  - h<=g, g<=f, f<=e, e<=d+t1, d<=c, c<=b, b<=a, a<=t1+t2.
  - All additions are modulo 2^WORD_W; carries are discarded.
  - round_idx increments.
  - On the edge where round_idx==ROUNDS-1, go FINAL; round_idx wraps to 0.
- FINAL, one cycle: hash_out[i] <= saved H[i] + var[i] mod 2^WORD_W for all eight words; done=1 for exactly this one cycle after the edge; go IDLE.
- Latency without stall: load edge, then ROUNDS RUN edges, then the FINAL edge. done is visible ROUNDS+1 edges after the load edge (65 at default).
- start while RUN or FINAL: ignored, no effect.
- start in the same cycle done is high: accepted, because the state is already IDLE. This gives back-to-back blocks with one idle edge.
- t1/t2 are sampled only on RUN advancing edges. round_idx is stable for the whole cycle in which the matching t1/t2 must be valid.
- busy=1 in RUN and FINAL, 0 in IDLE.
- vars_out continuously reflects the registers.

Optional Feature:
SHA_STEP_STALL_EN:
- Defined: the step_en port exists. RUN advances only on edges with step_en=1; with step_en=0, a..h and round_idx hold. FINAL and IDLE ignore step_en.
- Undefined: no step_en port, and RUN advances every edge.
- Latency becomes ROUNDS+1 plus the number of stalled RUN edges.

Test Plan:
1. rst=1 for 2 edges then 0, start=0 -> all outputs 0, busy=0, no done for 100 cycles.
2. h_in = standard SHA-256 IV (6a09e667..5be0cd19), bench model drives t1/t2 for the padded "abc" block -> done after 65 edges; hash_out = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
3. h_in = all 0xFFFFFFFF, t1=t2=0 for all rounds -> a..h all 0 before FINAL; hash_out = all 0xFFFFFFFF. In a second run with t1=1, t2=0 the final a = 1; check the a+H0 wrap to 0x00000000.
4. start pulsed at round 10 and again on the done cycle -> first pulse ignored (round_idx continues 11, 12, ...); second accepted, busy=1 next edge.
5. rst=1 at round 30 -> next edge IDLE, all registers 0, no done pulse.
6. (SHA_STEP_STALL_EN) step_en low on every other RUN edge, same vectors as test 2 -> identical hash_out, done after 129 edges.
